// File: rtl/ddc_ctrl.sv
// ddc_ctrl: shadow/live configuration registers and retune sequencer for the DDC chain.
// Optional `DDC_CTRL_FAST_RETUNE_EN: frequency-only commits skip the DDC reset hold.
module ddc_ctrl #(
  parameter int FSZ            = 26,
  parameter int OSZ            = 16,
  parameter int RST_CYCLES     = 64,
  parameter int SETTLE_SAMPLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_wr,
  input  logic [1:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic [31:0]           cfg_rdata,
  output logic                  ddc_reset,
  output logic [FSZ-1:0]        ddc_lo_freq,
  output logic                  ddc_lo_ns_en,
  output logic                  ddc_iq_swap,
  input  logic                  ddc_valid,
  input  logic signed [OSZ-1:0] ddc_i,
  input  logic signed [OSZ-1:0] ddc_q,
  output logic                  out_valid,
  output logic signed [OSZ-1:0] out_i,
  output logic signed [OSZ-1:0] out_q,
  output logic                  busy
);

  typedef enum logic [1:0] {HOLD = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;

  localparam int HW            = $clog2(RST_CYCLES + 1);
  localparam int SW            = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam int HOLD_LAST_I   = RST_CYCLES - 1;
  localparam int SETTLE_LAST_I = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;
  localparam logic [HW-1:0] HOLD_LAST   = HOLD_LAST_I[HW-1:0];
  localparam logic [SW-1:0] SETTLE_LAST = SETTLE_LAST_I[SW-1:0];
  localparam state_t AFTER_HOLD = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;

  state_t                state_reg, state_next;
  logic [HW-1:0]         hold_cnt_reg, hold_cnt_next;
  logic [SW-1:0]         settle_cnt_reg, settle_cnt_next;
  logic [15:0]           retune_cnt_reg, retune_cnt_next;
  logic [FSZ-1:0]        sh_freq_reg, sh_freq_next;
  logic                  sh_ns_reg, sh_ns_next;
  logic                  sh_iq_reg, sh_iq_next;
  logic [FSZ-1:0]        freq_reg, freq_next;
  logic                  ns_reg, ns_next;
  logic                  iq_reg, iq_next;
  logic                  out_valid_reg, out_valid_next;
  logic signed [OSZ-1:0] out_i_reg, out_i_next;
  logic signed [OSZ-1:0] out_q_reg, out_q_next;
  logic [31:0]           rdata_reg, rdata_next;
  logic                  apply;
  logic                  fast;
  logic                  wdata_unused;

  assign apply = cfg_wr && (cfg_addr == 2'd2) && cfg_wdata[0];

`ifdef DDC_CTRL_FAST_RETUNE_EN
  // Only a settled or running DDC may skip the flush; an in-progress hold always completes.
  assign fast = (state_reg != HOLD) && (sh_ns_reg == ns_reg) && (sh_iq_reg == iq_reg);
`else
  assign fast = 1'b0;
`endif

  assign wdata_unused = &{1'b0, cfg_wdata};

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    retune_cnt_next = retune_cnt_reg;
    sh_freq_next    = sh_freq_reg;
    sh_ns_next      = sh_ns_reg;
    sh_iq_next      = sh_iq_reg;
    freq_next       = freq_reg;
    ns_next         = ns_reg;
    iq_next         = iq_reg;
    out_valid_next  = 1'b0;
    out_i_next      = out_i_reg;
    out_q_next      = out_q_reg;
    rdata_next      = 32'd0;

    if (cfg_wr && cfg_addr == 2'd0) sh_freq_next = cfg_wdata[FSZ-1:0];
    if (cfg_wr && cfg_addr == 2'd1) {sh_iq_next, sh_ns_next} = cfg_wdata[1:0];

    if (apply) begin
      freq_next       = sh_freq_reg;
      ns_next         = sh_ns_reg;
      iq_next         = sh_iq_reg;
      retune_cnt_next = retune_cnt_reg + 16'd1;
      hold_cnt_next   = '0;
      settle_cnt_next = '0;
      state_next      = fast ? AFTER_HOLD : HOLD;
    end else begin
      case (state_reg)
        HOLD: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            state_next      = AFTER_HOLD;
            settle_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        SETTLE: begin
          if (ddc_valid) begin
            if (settle_cnt_reg == SETTLE_LAST) state_next = RUN;
            else settle_cnt_next = settle_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          out_valid_next = ddc_valid;
          if (ddc_valid) begin
            out_i_next = ddc_i;
            out_q_next = ddc_q;
          end
        end
        default: begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      endcase
    end

    case (cfg_addr)
      2'd0:    rdata_next = 32'(sh_freq_reg);
      2'd1:    rdata_next = {30'd0, sh_iq_reg, sh_ns_reg};
      2'd2:    rdata_next = 32'd0;
      default: rdata_next = {retune_cnt_reg, 13'd0, state_reg, busy};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= HOLD;
      hold_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      retune_cnt_reg <= '0;
      sh_freq_reg    <= '0;
      sh_ns_reg      <= 1'b0;
      sh_iq_reg      <= 1'b0;
      freq_reg       <= '0;
      ns_reg         <= 1'b0;
      iq_reg         <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_i_reg      <= '0;
      out_q_reg      <= '0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      retune_cnt_reg <= retune_cnt_next;
      sh_freq_reg    <= sh_freq_next;
      sh_ns_reg      <= sh_ns_next;
      sh_iq_reg      <= sh_iq_next;
      freq_reg       <= freq_next;
      ns_reg         <= ns_next;
      iq_reg         <= iq_next;
      out_valid_reg  <= out_valid_next;
      out_i_reg      <= out_i_next;
      out_q_reg      <= out_q_next;
      rdata_reg      <= rdata_next;
    end
  end

  assign busy         = (state_reg != RUN);
  assign ddc_reset    = (state_reg == HOLD);
  assign ddc_lo_freq  = freq_reg;
  assign ddc_lo_ns_en = ns_reg;
  assign ddc_iq_swap  = iq_reg;
  assign out_valid    = out_valid_reg;
  assign out_i        = out_i_reg;
  assign out_q        = out_q_reg;
  assign cfg_rdata    = rdata_reg;

endmodule

// File: tb/tb_ddc_ctrl.sv
// tb_ddc_ctrl: directed retune sequences, a register-map vector table and a randomized run,
// all checked every cycle against a countdown-based reference model.
module tb_ddc_ctrl;
  localparam int FSZ = 26, OSZ = 16, RST_CYCLES = 64, SETTLE_SAMPLES = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_wr = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic ddc_reset, ddc_lo_ns_en, ddc_iq_swap, out_valid, busy;
  logic [FSZ-1:0] ddc_lo_freq;
  logic ddc_valid = 1'b0;
  logic signed [OSZ-1:0] ddc_i = '0, ddc_q = '0;
  logic signed [OSZ-1:0] out_i, out_q;

  always #5 clk = ~clk;

  ddc_ctrl #(.FSZ(FSZ), .OSZ(OSZ), .RST_CYCLES(RST_CYCLES), .SETTLE_SAMPLES(SETTLE_SAMPLES)) dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .ddc_reset(ddc_reset), .ddc_lo_freq(ddc_lo_freq),
    .ddc_lo_ns_en(ddc_lo_ns_en), .ddc_iq_swap(ddc_iq_swap), .ddc_valid(ddc_valid),
    .ddc_i(ddc_i), .ddc_q(ddc_q), .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
    .busy(busy));

  int checks = 0;
  int failures = 0;
  int ov_count = 0;

  // Reference model: phase 0=HOLD 1=SETTLE 2=RUN, with remaining-cycle / remaining-sample counters.
  int m_phase, m_hold_left, m_settle_left;
  logic [FSZ-1:0] m_sh_freq, m_freq;
  logic m_sh_ns, m_sh_iq, m_ns, m_iq, m_ov;
  logic [15:0] m_retunes;
  logic signed [OSZ-1:0] m_oi, m_oq;
  logic [31:0] m_rdata;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_hold_left = RST_CYCLES; m_settle_left = SETTLE_SAMPLES;
    m_sh_freq = '0; m_freq = '0; m_sh_ns = 0; m_sh_iq = 0; m_ns = 0; m_iq = 0;
    m_ov = 0; m_oi = '0; m_oq = '0; m_retunes = '0; m_rdata = '0;
  endtask

  task automatic model_step();
    logic [31:0] rd;
    logic is_apply, skip;
    case (cfg_addr)
      2'd0:    rd = 32'(m_sh_freq);
      2'd1:    rd = {30'd0, m_sh_iq, m_sh_ns};
      2'd2:    rd = 32'd0;
      default: rd = {m_retunes, 13'd0, 2'(m_phase), 1'(m_phase != 2)};
    endcase
    if (reset) begin
      model_reset();
      return;
    end
    m_rdata = rd;
    is_apply = cfg_wr && cfg_addr == 2'd2 && cfg_wdata[0];
    skip = 1'b0;
`ifdef DDC_CTRL_FAST_RETUNE_EN
    skip = (m_phase != 0) && (m_sh_ns == m_ns) && (m_sh_iq == m_iq);
`endif
    m_ov = 1'b0;
    if (is_apply) begin
      m_freq = m_sh_freq; m_ns = m_sh_ns; m_iq = m_sh_iq;
      m_retunes = m_retunes + 16'd1;
      if (skip) begin
        m_phase = (SETTLE_SAMPLES == 0) ? 2 : 1;
        m_settle_left = SETTLE_SAMPLES;
      end else begin
        m_phase = 0;
        m_hold_left = RST_CYCLES;
      end
    end else if (m_phase == 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_phase = (SETTLE_SAMPLES == 0) ? 2 : 1;
        m_settle_left = SETTLE_SAMPLES;
      end
    end else if (m_phase == 1) begin
      if (ddc_valid) begin
        m_settle_left--;
        if (m_settle_left == 0) m_phase = 2;
      end
    end else begin
      m_ov = ddc_valid;
      if (ddc_valid) begin
        m_oi = ddc_i;
        m_oq = ddc_q;
      end
    end
    if (cfg_wr && cfg_addr == 2'd0) m_sh_freq = cfg_wdata[FSZ-1:0];
    if (cfg_wr && cfg_addr == 2'd1) {m_sh_iq, m_sh_ns} = cfg_wdata[1:0];
  endtask

  task automatic compare_all();
    chk("ddc_reset", 32'(ddc_reset), 32'(m_phase == 0));
    chk("busy", 32'(busy), 32'(m_phase != 2));
    chk("ddc_lo_freq", 32'(ddc_lo_freq), 32'(m_freq));
    chk("ddc_lo_ns_en", 32'(ddc_lo_ns_en), 32'(m_ns));
    chk("ddc_iq_swap", 32'(ddc_iq_swap), 32'(m_iq));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_i", 32'(out_i), 32'(m_oi));
    chk("out_q", 32'(out_q), 32'(m_oq));
    chk("cfg_rdata", cfg_rdata, m_rdata);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) ov_count++;
    compare_all();
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    cfg_wr = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_wr = 1'b0; cfg_wdata = 32'd0;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [31:0] data);
    cfg_addr = addr;
    tick();
    data = cfg_rdata;
  endtask

  task automatic count_reset_high(output int n);
    n = 0;
    while (ddc_reset && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic count_settle(output int n);
    n = 0;
    ddc_valid = 1'b1;
    while (busy && n < 200) begin
      ddc_i = OSZ'($urandom); ddc_q = OSZ'($urandom);
      n++;
      tick();
    end
  endtask

  task automatic run_to_run();
    int n;
    n = 0;
    ddc_valid = 1'b1;
    while (busy && n < 300) begin
      n++;
      tick();
    end
    chk("run_to_run_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, ov0;
    logic [31:0] r;
    model_reset();
    vecs[0] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h03FF_FFFF};
    vecs[1] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[2] = '{1'b1, 2'd1, 32'h0000_0001, 32'h0000_0001};
    vecs[3] = '{1'b1, 2'd2, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 2'd0, 32'h0000_ABCD, 32'h0000_ABCD};
    vecs[5] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0004_0004};

    // 1: reset release, 64-cycle hold, 8 discarded samples, first passed sample.
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_rdata", cfg_rdata, 32'd0);
    chk("reset_ddc_reset", 32'(ddc_reset), 32'd1);
    reset = 1'b0;
    count_reset_high(n);
    chk("t1_hold_len", 32'(n), 32'd64);
    ov0 = ov_count;
    count_settle(n);
    chk("t1_settle_len", 32'(n), 32'd8);
    chk("t1_no_ov_settle", 32'(ov_count - ov0), 32'd0);
    chk("t1_busy_fell", 32'(busy), 32'd0);
    ddc_i = 16'sh1234; ddc_q = -16'sd5;
    tick();
    chk("t1_first_valid", 32'(out_valid), 32'd1);
    chk("t1_first_i", 32'(out_i), 32'h0000_1234);
    chk("t1_first_q", 32'(out_q), 32'hFFFF_FFFB);

    // 2: FREQ write is shadow-only until APPLY.
    wr(2'd0, 32'h0155_5555);
    chk("t2_freq_before", 32'(ddc_lo_freq), 32'd0);
    wr(2'd2, 32'd1);
    chk("t2_freq_after", 32'(ddc_lo_freq), 32'h0155_5555);
    chk("t2_no_ov_after_apply", 32'(out_valid), 32'd0);
    rd(2'd3, r);
    chk("t2_status", r, 32'h0001_0001);
    run_to_run();

    // 3: CTRL iq_swap shadow, committed with a reset pulse.
    wr(2'd1, 32'd2);
    repeat (3) tick();
    chk("t3_iq_before", 32'(ddc_iq_swap), 32'd0);
    wr(2'd2, 32'd1);
    chk("t3_iq_after", 32'(ddc_iq_swap), 32'd1);
    chk("t3_reset_pulse", 32'(ddc_reset), 32'd1);

    // 4: APPLY at hold cycle 40 restarts the full hold.
    ddc_valid = 1'b0;
    repeat (40) tick();
    wr(2'd2, 32'd1);
    count_reset_high(n);
    chk("t4_hold_restart_len", 32'(n), 32'd64);
    rd(2'd3, r);
    chk("t4_status", r, 32'h0003_0003);

    // 5: APPLY after 3 settle samples re-enters HOLD and discards 8 fresh samples.
    ov0 = ov_count;
    ddc_valid = 1'b1;
    repeat (3) tick();
    chk("t5_still_settle", 32'(busy), 32'd1);
    wr(2'd2, 32'd1);
    chk("t5_back_in_hold", 32'(ddc_reset), 32'd1);
    count_reset_high(n);
    chk("t5_hold_len", 32'(n), 32'd64);
    count_settle(n);
    chk("t5_settle_len", 32'(n), 32'd8);
    chk("t5_no_ov", 32'(ov_count - ov0), 32'd0);

    // Register map vectors (in RUN, retune count 4).
    foreach (vecs[k]) begin
      ddc_valid = 1'($urandom); ddc_i = OSZ'($urandom); ddc_q = OSZ'($urandom);
      if (vecs[k].wr) wr(vecs[k].addr, vecs[k].wdata);
      rd(vecs[k].addr, r);
      chk($sformatf("vec%0d_rdata", k), r, vecs[k].exp_rdata);
    end
    chk("vec_live_freq_kept", 32'(ddc_lo_freq), 32'h0155_5555);

`ifdef DDC_CTRL_FAST_RETUNE_EN
    // 6: frequency-only APPLY skips the DDC reset but still blanks settling samples.
    run_to_run();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h00AB_CDEF);
    wr(2'd2, 32'd1);
    chk("t6_no_reset", 32'(ddc_reset), 32'd0);
    chk("t6_freq", 32'(ddc_lo_freq), 32'h00AB_CDEF);
    ov0 = ov_count;
    count_settle(n);
    chk("t6_settle_len", 32'(n), 32'd8);
    chk("t6_no_ov", 32'(ov_count - ov0), 32'd0);
    tick();
    chk("t6_run_resumed", 32'(out_valid), 32'd1);
`endif

    // Randomized traffic against the model, including occasional mid-sequence resets.
    for (int c = 0; c < 2500; c++) begin
      reset     = ($urandom_range(0, 499) == 0);
      cfg_wr    = ($urandom_range(0, 11) == 0);
      cfg_addr  = 2'($urandom);
      cfg_wdata = $urandom;
      ddc_valid = 1'($urandom);
      ddc_i     = OSZ'($urandom);
      ddc_q     = OSZ'($urandom);
      tick();
    end
    reset = 1'b0; cfg_wr = 1'b0; ddc_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
